// File: rtl/multibyte_carry_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : multibyte_carry_sequencer
//  Description : Byte-serial wide adder stage. Accepts operand slices LSB beat
//                first over valid/ready and adds one WIDTH-bit slice per beat.
//                A registered carry links consecutive beats, so arbitrarily
//                wide sums need only one WIDTH-bit adder.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                in_valid/in_ready   - input beat handshake
//                in_a, in_b          - operand slices
//                in_cin              - carry-in, used on the first beat only
//                in_last             - final (MSB) beat of the operation
//                out_valid/out_ready - output beat handshake
//                out_sum, out_cout   - sum slice and its carry-out
//                out_last, out_beat  - last flag and beat index
//                busy                - an operation is open
//  Revision    : 1.0 - initial release
// ============================================================================
module multibyte_carry_sequencer #(
    parameter int WIDTH  = 8,
    parameter int BEAT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic              in_cin,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_sum,
    output logic              out_cout,
    output logic              out_last,
    output logic [BEAT_W-1:0] out_beat,
    output logic              busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_carry;
    logic               w_carry_next;
    logic [BEAT_W-1:0]  r_cnt;
    logic [BEAT_W-1:0]  w_cnt_next;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_sum;
    logic               r_out_cout;
    logic               r_out_last;
    logic [BEAT_W-1:0]  r_out_beat;

    logic               w_accept;
    logic               w_cin_sel;
    logic [WIDTH:0]     w_sum;

    // Single-entry output register: a new beat may enter only when the
    // register is empty or is being drained in this same cycle.
    assign in_ready = !rst && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // The first beat takes its carry from the port; later beats chain the
    // carry produced by the previous slice.
    assign w_cin_sel = (r_state == ST_RUN) ? r_carry : in_cin;
    assign w_sum     = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, w_cin_sel};

    always_comb begin
        w_state_next = r_state;
        w_carry_next = r_carry;
        w_cnt_next   = r_cnt;
        if (w_accept) begin
            if (in_last) begin
                // Operation closes: nothing may leak into the next one.
                w_state_next = ST_IDLE;
                w_carry_next = 1'b0;
                w_cnt_next   = '0;
            end else begin
                w_state_next = ST_RUN;
                w_carry_next = w_sum[WIDTH];
                w_cnt_next   = r_cnt + {{(BEAT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_carry <= w_carry_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_cout  <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_beat  <= '0;
        end else if (w_accept) begin
            // Also covers the same-cycle drain-and-refill case.
            r_out_valid <= 1'b1;
            r_out_sum   <= w_sum[WIDTH-1:0];
            r_out_cout  <= w_sum[WIDTH];
            r_out_last  <= in_last;
            r_out_beat  <= r_cnt;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_cout  = r_out_cout;
    assign out_last  = r_out_last;
    assign out_beat  = r_out_beat;
    assign busy      = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_multibyte_carry_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multibyte_carry_sequencer
//  Description : Self-checking bench for multibyte_carry_sequencer. A model
//                computes each output beat from whole-operand arithmetic and
//                tracks the pending output beat; a compare process checks the
//                DUT every cycle. Literal checks pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multibyte_carry_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_cin;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_cout;
    logic       out_last;
    logic [3:0] out_beat;
    logic       busy;

    multibyte_carry_sequencer #(.WIDTH(8), .BEAT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_last  (out_last),
        .out_beat  (out_beat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected value of the beat currently presented by the driver.
    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       l;
        logic [3:0] b;
    } exp_t;

    exp_t d_exp;
    exp_t mq[$];
    logic m_open  = 1'b0;
    logic m_known = 1'b0;
    logic exp_ready;

    int lg_sum[$];
    int lg_cout[$];
    int lg_last[$];
    int lg_beat[$];
    int lg_cyc[$];

    // Per-cycle compare against the model; updates model for the next edge.
    always @(negedge clk) begin
        if (m_known) begin
            exp_ready = !rst && (mq.size() == 0 || out_ready);
            chk("in_ready", in_ready, exp_ready);
            chk("out_valid", out_valid, mq.size() != 0);
            chk("busy", busy, m_open);
            if (mq.size() != 0) begin
                chk("out_sum", out_sum, mq[0].s);
                chk("out_cout", out_cout, mq[0].c);
                chk("out_last", out_last, mq[0].l);
                chk("out_beat", out_beat, mq[0].b);
            end
            if (out_valid && out_ready && !rst) begin
                lg_sum.push_back(out_sum);
                lg_cout.push_back(out_cout);
                lg_last.push_back(out_last);
                lg_beat.push_back(out_beat);
                lg_cyc.push_back(cyc);
            end
            if (rst) begin
                mq.delete();
                m_open = 1'b0;
            end else begin
                if (mq.size() != 0 && out_ready) void'(mq.pop_front());
                if (in_valid && exp_ready) begin
                    mq.push_back(d_exp);
                    m_open = !in_last;
                end
            end
        end else if (rst) begin
            m_known = 1'b1;
            mq.delete();
            m_open  = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends beats 0..n-1 of an operation whose last beat is total_n-1.
    // Called and returns at posedge+1.
    task automatic send_op(input logic [255:0] a, input logic [255:0] b,
                           input logic cin, input int n, input int total_n);
        logic [255:0] mask;
        logic [255:0] part;
        int w;
        for (int i = 0; i < n; i++) begin
            mask = (256'd1 << (8 * (i + 1))) - 256'd1;
            part = (a & mask) + (b & mask) + {255'd0, cin};
            in_valid = 1'b1;
            in_a     = a[8*i +: 8];
            in_b     = b[8*i +: 8];
            in_cin   = (i == 0) ? cin : ~cin;
            in_last  = (i == total_n - 1);
            d_exp.s  = part[8*i +: 8];
            d_exp.c  = part[8*(i+1)];
            d_exp.l  = (i == total_n - 1);
            d_exp.b  = 4'(i % 16);
            w = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                w++;
                if (w > 100) begin
                    total++;
                    bad++;
                    $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
                    break;
                end
            end
            tick(1);
        end
        in_valid = 1'b0;
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        in_cin   = 1'($urandom);
        in_last  = 1'($urandom);
    endtask

    int base;
    logic [255:0] wa;
    logic [255:0] wb;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00;
        in_cin = 1'b0; in_last = 1'b0; out_ready = 1'b1; d_exp = '0;
        tick(3);
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_cout", out_cout, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_beat", out_beat, 0);
        chk("rst_busy", busy, 0);

        // Single beat 0x0F + 0x01
        base = lg_sum.size();
        send_op(256'h0F, 256'h01, 1'b0, 1, 1);
        tick(2);
        chk("t1_count", lg_sum.size() - base, 1);
        chk("t1_sum", lg_sum[base], 32'h10);
        chk("t1_cout", lg_cout[base], 0);
        chk("t1_last", lg_last[base], 1);
        chk("t1_beat", lg_beat[base], 0);

        // 0x00FF + 0x0001
        base = lg_sum.size();
        send_op(256'h00FF, 256'h0001, 1'b0, 2, 2);
        tick(2);
        chk("t2_sum0", lg_sum[base], 32'h00);
        chk("t2_cout0", lg_cout[base], 1);
        chk("t2_beat0", lg_beat[base], 0);
        chk("t2_sum1", lg_sum[base+1], 32'h01);
        chk("t2_cout1", lg_cout[base+1], 0);
        chk("t2_last1", lg_last[base+1], 1);
        chk("t2_beat1", lg_beat[base+1], 1);

        // 0xFFFF + 0x0000 + 1
        base = lg_sum.size();
        send_op(256'hFFFF, 256'h0000, 1'b1, 2, 2);
        tick(2);
        chk("t3_sum0", lg_sum[base], 32'h00);
        chk("t3_cout0", lg_cout[base], 1);
        chk("t3_sum1", lg_sum[base+1], 32'h00);
        chk("t3_cout1", lg_cout[base+1], 1);
        chk("t3_last1", lg_last[base+1], 1);

        // Backpressure for 3 cycles mid-op
        base = lg_sum.size();
        fork
            send_op(256'h12_34_56, 256'hAB_CD_EF, 1'b1, 3, 3);
            begin
                tick(1);
                out_ready = 1'b0;
                tick(3);
                out_ready = 1'b1;
            end
        join
        tick(2);
        chk("t4_count", lg_sum.size() - base, 3);
        chk("t4_sum2", lg_sum[base+2], 32'hBE);
        chk("t4_last2", lg_last[base+2], 1);

        // Reset mid-op with a pending beat and a beat offered during reset
        out_ready = 1'b0;
        send_op(256'h00FF, 256'h0001, 1'b0, 1, 2);
        rst = 1'b1; in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_last = 1'b0;
        tick(1);
        rst = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_busy", busy, 0);
        base = lg_sum.size();
        send_op(256'h01, 256'h01, 1'b0, 1, 1);
        tick(2);
        chk("t5_count", lg_sum.size() - base, 1);
        chk("t5_sum", lg_sum[base], 32'h02);
        chk("t5_cout", lg_cout[base], 0);

        // Throughput: 4 beats on 4 consecutive cycles
        base = lg_sum.size();
        send_op(256'h8899AABB, 256'h77665545, 1'b0, 4, 4);
        tick(2);
        chk("t6_count", lg_sum.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t6_beat", lg_beat[base+i], i);
            chk("t6_last", lg_last[base+i], (i == 3) ? 1 : 0);
            if (i > 0) chk("t6_consec", lg_cyc[base+i] - lg_cyc[base+i-1], 1);
        end
        chk("t6_sum3", lg_sum[base+3], 32'h00);
        chk("t6_cout3", lg_cout[base+3], 1);

        // Beat index wrap on an 18-beat op
        wa = '0;
        wb = '0;
        for (int i = 0; i < 18; i++) begin
            wa[8*i +: 8] = 8'($urandom);
            wb[8*i +: 8] = 8'($urandom);
        end
        base = lg_sum.size();
        send_op(wa, wb, 1'b1, 18, 18);
        tick(2);
        chk("wrap_count", lg_sum.size() - base, 18);
        chk("wrap_beat15", lg_beat[base+15], 15);
        chk("wrap_beat16", lg_beat[base+16], 0);
        chk("wrap_beat17", lg_beat[base+17], 1);
        chk("wrap_last17", lg_last[base+17], 1);

        // Back-to-back ops: next op starts at beat 0 with its own carry-in
        base = lg_sum.size();
        send_op(256'hFFFF, 256'h0001, 1'b0, 2, 2);
        send_op(256'h10, 256'h20, 1'b0, 1, 1);
        tick(2);
        chk("b2b_beat", lg_beat[base+2], 0);
        chk("b2b_sum", lg_sum[base+2], 32'h30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
